// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pkg : state encodings, frame width and baud-divider helper       |
// |            shared by the UART transmitter and receiver.               |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_START     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA      = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY    = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP      = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_HIGH = 3'd5;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_sync : two-flop synchronizer for an asynchronous input whose  |
// |                idle level is high (flops preset to 1 on reset).       |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx : polled 8N1 serial receiver with a one-byte holding register |
// |           and sticky frame/overrun flags. Define UART_RX_PARITY_EN    |
// |           for 8E1 framing with a sticky parity_error output.          |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       read_en,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_divider
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic                 rx_s;
  logic [STATE_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 byte_done;
  logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error_q, parity_error_d;
  logic                 parity_bad;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      data_q         <= '0;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      data_q         <= data_d;
      rx_valid_q     <= rx_valid_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= parity_error_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          cnt_d     = FULL_RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = FULL_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Even parity: data bits plus parity bit must XOR to zero.
          parity_bad = (^shift_q) ^ rx_s;
          cnt_d      = FULL_RELOAD;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          byte_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stop_bad = 1'b1;
          state_d  = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A read in the same cycle as a completion consumes the old byte, so no overrun.
  always_comb begin
    data_d        = data_q;
    rx_valid_d    = rx_valid_q;
    frame_error_d = frame_error_q;
    overrun_d     = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_error_d = parity_error_q;
    if (read_en) begin
      parity_error_d = 1'b0;
    end
    if (parity_bad) begin
      parity_error_d = 1'b1;
    end
`endif
    if (read_en) begin
      rx_valid_d    = 1'b0;
      frame_error_d = 1'b0;
      overrun_d     = 1'b0;
    end
    if (byte_done) begin
      data_d     = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !read_en) begin
        overrun_d = 1'b1;
      end
    end
    if (stop_bad) begin
      frame_error_d = 1'b1;
    end
  end

  assign rx_busy     = (state_q != ST_IDLE);
  assign data        = data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_rx : randomized/directed bench for uart_rx with a byte        |
// |              scoreboard; UART_RX_PARITY_EN adds the 8E1 checks.       |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
module tb_uart_rx;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = CPB;
`else
  localparam int EXTRA = 0;
`endif
  // Edges after the first sampling edge of the start bit until the byte shows.
  localparam int LAT = 97 + EXTRA;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       read_en;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  logic       par_flip = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .read_en     (read_en),
    .data        (data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .rx_busy     (rx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Frame built from the line rules: low start, LSB-first data, optional even parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_val = 1'b1,
                            input int stop_len = CPB);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_flip, CPB);
`endif
    drive(stop_val, stop_len);
  endtask

  task automatic pulse_read();
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!rx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!rx_valid) begin
      fails++;
      $display("FAIL %s: rx_valid got 0 expected 1 within 300 cycles", name);
    end
  endtask

  // Monitor: a byte is presented when valid rises, or valid holds across a read
  // or overrun-raising completion.
  initial begin : monitor
    logic prev_v = 1'b0;
    logic prev_ov = 1'b0;
    logic rd_edge;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      rd_edge = read_en;
      #1;
      if (rst) begin
        prev_v  = 1'b0;
        prev_ov = 1'b0;
      end else begin
        if (rx_valid && (!prev_v || rd_edge || (overrun && !prev_ov))) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got byte 0x%0h expected none", data);
          end else begin
            e = exp_q.pop_front();
            if (data !== e) begin
              fails++;
              $display("FAIL sb_data: got 0x%0h expected 0x%0h", data, e);
            end
          end
        end
        prev_v  = rx_valid;
        prev_ov = overrun;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation got no finish expected finish by 2ms");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int g;
    logic [7:0] b;
    rst = 1'b1; rx = 1'b1; read_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", rx_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovr", overrun, 0);

    // Single frame and first-byte latency.
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55);
      begin
        @(posedge clk);
        n = 0;
        while (!rx_valid && n < LAT) begin
          @(posedge clk); #1; n++;
        end
        check("latency_valid", rx_valid, 1);
      end
    join
    check("f55_data", data, 8'h55);
    check("f55_ferr", frame_error, 0);
    check("f55_ovr", overrun, 0);
    pulse_read();
    check("f55_read_clears", rx_valid, 0);
    pulse_read();
    check("read_idle_keeps_data", data, 8'h55);

    // Back-to-back frames; the busy gap can be at most the half stop bit left after sampling.
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    g = 0;
    fork
      begin send_frame(8'hA3); send_frame(8'h0F); end
      begin wait_valid("b2b_first"); pulse_read(); wait_valid("b2b_second"); pulse_read(); end
      begin
        n = 0;
        while (!rx_busy && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (rx_busy && n < 200) begin @(negedge clk); n++; end
        while (!rx_busy && g < 50) begin @(negedge clk); g++; end
      end
    join
    tests++;
    if (g > CPB / 2) begin
      fails++;
      $display("FAIL b2b_busy_gap: got %0d cycles expected <= %0d", g, CPB / 2);
    end
    repeat (5) @(negedge clk);

    // Overrun without read, then completion coinciding with read.
    exp_q.push_back(8'h11); send_frame(8'h11);
    exp_q.push_back(8'h22); send_frame(8'h22);
    check("ovr_data", data, 8'h22);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", overrun, 1);
    pulse_read();
    check("ovr_cleared", overrun, 0);
    exp_q.push_back(8'h11); send_frame(8'h11);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22);
      begin repeat (LAT) @(posedge clk); @(negedge clk); pulse_read(); end
    join
    check("sim_read_valid", rx_valid, 1);
    check("sim_read_ovr", overrun, 0);
    check("sim_read_data", data, 8'h22);
    pulse_read();

    // Stop bit held low: frame error, receiver waits for the line to return high.
    send_frame(8'hFF, 1'b0, 2 * CPB);
    check("ferr_flag", frame_error, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_wait_high_busy", rx_busy, 1);
    drive(1'b1, 4);
    check("ferr_released", rx_busy, 0);
    exp_q.push_back(8'h3C); send_frame(8'h3C);
    check("after_ferr_data", data, 8'h3C);
    pulse_read();
    check("ferr_cleared", frame_error, 0);

    // Short low glitch on an idle line.
    drive(1'b0, 3);
    drive(1'b1, 2 * CPB);
    check("glitch_valid", rx_valid, 0);
    check("glitch_busy", rx_busy, 0);
    check("glitch_flags", {frame_error, overrun}, 2'b00);

    // Reset after four data bits discards the partial byte.
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(i[0], CPB);
    rst = 1'b1; rx = 1'b1;
    #1;
    check("midrst_outs", {data, rx_valid, frame_error, overrun, rx_busy}, 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, CPB);
    check("midrst_no_valid", rx_valid, 0);
    exp_q.push_back(8'h81); send_frame(8'h81);
    check("midrst_next_data", data, 8'h81);
    pulse_read();

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    exp_q.push_back(8'h07); send_frame(8'h07);
    check("par_bad_flag", parity_error, 1);
    check("par_bad_data", data, 8'h07);
    check("par_bad_valid", rx_valid, 1);
    pulse_read();
    par_flip = 1'b0;
    exp_q.push_back(8'h07); send_frame(8'h07);
    check("par_good_flag", parity_error, 0);
    pulse_read();
`endif

    // Random bytes with random idle gaps, read after each.
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      drive(1'b1, int'($urandom_range(0, 15)));
      exp_q.push_back(b);
      send_frame(b);
      check("rand_ovr", overrun, 0);
      pulse_read();
    end

    repeat (20) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
